cbfp1_bitrev_reorder: RTL

Reorder buffer directly downstream of the stage-1 CBFP normaliser. Collects one 512-point frame, arriving as 32 batches of 16 complex 12-bit samples each with a 5-bit block exponent, into one half of a ping-pong buffer. Replays the frame from bit-reversed addresses, 16 samples per cycle, so later stages and the host see natural-order bins with their exponents attached.

---
 rtl/fft_pkg.sv | 37 +++
 rtl/cbfp1_bitrev_reorder_if.sv | 34 +++
 rtl/reorder_bank.sv | 40 ++++
 rtl/cbfp1_bitrev_reorder.sv | 141 ++++++++++++++
 4 files changed

// File: rtl/fft_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : fft_pkg
//  Purpose  : Shared FFT constants, the CBFP sample record and the 9-bit
//             address bit-reversal helper.
//  Revision : 1.0  initial release
// ============================================================================
package fft_pkg;

   localparam int N_POINT    = 512;
   localparam int BATCH_SIZE = 16;
   localparam int N_BATCH    = 32;
   localparam int ADDR_W     = 9;
   localparam int LANE_W     = 4;   // log2(BATCH_SIZE)
   localparam int BATCH_W    = 5;   // log2(N_BATCH)
   localparam int BW_DATA    = 12;
   localparam int BW_IDX     = 5;

   // One stored sample: real, imaginary and its block exponent
   typedef struct packed {
      logic signed [BW_DATA-1:0] re;
      logic signed [BW_DATA-1:0] im;
      logic        [BW_IDX-1:0]  idx;
   } cbfp_sample_t;

   // Reverse all address bits (MSB <-> LSB)
   function automatic logic [ADDR_W-1:0] bitrev9(input logic [ADDR_W-1:0] a);
      logic [ADDR_W-1:0] r;
      r = '0;
      for (int i = 0; i < ADDR_W; i++) begin
         r[i] = a[ADDR_W-1-i];
      end
      return r;
   endfunction

endpackage
`default_nettype wire

// File: rtl/cbfp1_bitrev_reorder_if.sv
`default_nettype none
// ============================================================================
//  Module   : cbfp1_bitrev_reorder_if
//  Purpose  : Batch input / reordered batch output bundle of the stage-1
//             reorder buffer. master = producer/consumer side, slave = buffer.
//  Revision : 1.0  initial release
// ============================================================================
interface cbfp1_bitrev_reorder_if;
   import fft_pkg::*;

   logic [BATCH_SIZE-1:0][BW_DATA-1:0] real_in;
   logic [BATCH_SIZE-1:0][BW_DATA-1:0] imag_in;
   logic [BATCH_SIZE-1:0][BW_IDX-1:0]  index_in;
   logic                               in_valid;

   logic [BATCH_SIZE-1:0][BW_DATA-1:0] real_out;
   logic [BATCH_SIZE-1:0][BW_DATA-1:0] imag_out;
   logic [BATCH_SIZE-1:0][BW_IDX-1:0]  index_out;
   logic                               valid_out;
   logic                               frame_start;
   logic                               frame_last;

   modport master (
      output real_in, imag_in, index_in, in_valid,
      input  real_out, imag_out, index_out, valid_out, frame_start, frame_last
   );

   modport slave (
      input  real_in, imag_in, index_in, in_valid,
      output real_out, imag_out, index_out, valid_out, frame_start, frame_last
   );

endinterface
`default_nettype wire

// File: rtl/reorder_bank.sv
`default_nettype none
// ============================================================================
//  Module   : reorder_bank
//  Purpose  : One 512-entry sample bank. 16-lane write of a whole batch at
//             {batch, lane}; 16 independent combinational read addresses.
//  Revision : 1.0  initial release
// ============================================================================
module reorder_bank
   import fft_pkg::*;
(
   input  wire  logic                               clk,
   input  wire  logic                               we,
   input  wire  logic [BATCH_W-1:0]                 wr_batch,
   input  wire  cbfp_sample_t [BATCH_SIZE-1:0]      wr_data,
   input  wire  logic [BATCH_SIZE-1:0][ADDR_W-1:0]  rd_addr,
   output       cbfp_sample_t [BATCH_SIZE-1:0]      rd_data
);

   // Contents are never cleared: every entry is written before it is read
   cbfp_sample_t r_mem [N_POINT];

   // Store the incoming batch at natural address batch*16 + lane
   always_ff @(posedge clk) begin
      if (we) begin
         for (int l = 0; l < BATCH_SIZE; l++) begin
            r_mem[{wr_batch, LANE_W'(l)}] <= wr_data[l];
         end
      end
   end

   // Address-mapped read, one independent address per lane
   always_comb begin
      rd_data = '0;
      for (int l = 0; l < BATCH_SIZE; l++) begin
         rd_data[l] = r_mem[rd_addr[l]];
      end
   end

endmodule
`default_nettype wire

// File: rtl/cbfp1_bitrev_reorder.sv
`default_nettype none
// ============================================================================
//  Module   : cbfp1_bitrev_reorder
//  Purpose  : Ping-pong reorder buffer behind the stage-1 CBFP normaliser.
//             Collects 32 batches of 16 samples into one bank, then replays
//             the bank from bit-reversed addresses so downstream sees
//             natural-order bins with their exponents attached.
//  Revision : 1.0  initial release
// ============================================================================
module cbfp1_bitrev_reorder #(
   parameter int BW_DATA    = 12,
   parameter int BW_IDX     = 5,
   parameter int BATCH_SIZE = 16,
   parameter int N_POINT    = 512
) (
   input  wire logic                clk,
   input  wire logic                rst,
   cbfp1_bitrev_reorder_if.slave    bus
);
   import fft_pkg::cbfp_sample_t;
   import fft_pkg::bitrev9;
   import fft_pkg::ADDR_W;
   import fft_pkg::BATCH_W;
   import fft_pkg::LANE_W;

   localparam int                 c_N_BATCH    = N_POINT / BATCH_SIZE;
   localparam logic [BATCH_W-1:0] c_LAST_BATCH = BATCH_W'(c_N_BATCH - 1);

   localparam logic [0:0] c_ST_IDLE = 1'b0;
   localparam logic [0:0] c_ST_READ = 1'b1;

   logic [BATCH_W-1:0] r_wr_cnt;
   logic               r_wr_bank;
   logic [BATCH_W-1:0] r_rd_cnt;
   logic               r_rd_bank;
   logic [0:0]         r_state;

   logic               w_wr_en;
   logic               w_launch;
   cbfp_sample_t [BATCH_SIZE-1:0]      w_wr_data;
   logic [BATCH_SIZE-1:0][ADDR_W-1:0]  w_rd_addr;
   cbfp_sample_t [BATCH_SIZE-1:0]      w_rd_data [2];

   // Writes are suppressed while reset is held; the last batch launches a read
   always_comb begin
      w_wr_en  = bus.in_valid & ~rst;
      w_launch = w_wr_en && (r_wr_cnt == c_LAST_BATCH);
   end

   // Pack lanes into bank records and form bit-reversed read addresses
   always_comb begin
      w_wr_data = '0;
      w_rd_addr = '0;
      for (int l = 0; l < BATCH_SIZE; l++) begin
         w_wr_data[l].re  = bus.real_in[l];
         w_wr_data[l].im  = bus.imag_in[l];
         w_wr_data[l].idx = bus.index_in[l];
         w_rd_addr[l]     = bitrev9({r_rd_cnt, LANE_W'(l)});
      end
   end

   generate
      for (genvar b = 0; b < 2; b++) begin : g_bank
         reorder_bank u_bank (
            .clk      (clk),
            .we       (w_wr_en && (r_wr_bank == 1'(b))),
            .wr_batch (r_wr_cnt),
            .wr_data  (w_wr_data),
            .rd_addr  (w_rd_addr),
            .rd_data  (w_rd_data[b])
         );
      end
   endgenerate

   // Write batch counter; flips the bank on each completed frame
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_wr_cnt  <= '0;
         r_wr_bank <= 1'b0;
      end else if (bus.in_valid) begin
         if (r_wr_cnt == c_LAST_BATCH) begin
            r_wr_cnt  <= '0;
            r_wr_bank <= ~r_wr_bank;
         end else begin
            r_wr_cnt  <= r_wr_cnt + 1'b1;
         end
      end
   end

   // Read FSM; a launch on the final read batch restarts for gapless output
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state   <= c_ST_IDLE;
         r_rd_cnt  <= '0;
         r_rd_bank <= 1'b0;
      end else if (w_launch) begin
         r_state   <= c_ST_READ;
         r_rd_cnt  <= '0;
         r_rd_bank <= r_wr_bank;
      end else if (r_state == c_ST_READ) begin
         if (r_rd_cnt == c_LAST_BATCH) begin
            r_state  <= c_ST_IDLE;
            r_rd_cnt <= '0;
         end else begin
            r_rd_cnt <= r_rd_cnt + 1'b1;
         end
      end
   end

   // Registered outputs, forced to zero whenever no batch is being replayed
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         bus.real_out    <= '0;
         bus.imag_out    <= '0;
         bus.index_out   <= '0;
         bus.valid_out   <= 1'b0;
         bus.frame_start <= 1'b0;
         bus.frame_last  <= 1'b0;
      end else if (r_state == c_ST_READ) begin
         for (int l = 0; l < BATCH_SIZE; l++) begin
            bus.real_out[l]  <= w_rd_data[r_rd_bank][l].re;
            bus.imag_out[l]  <= w_rd_data[r_rd_bank][l].im;
            bus.index_out[l] <= w_rd_data[r_rd_bank][l].idx;
         end
         bus.valid_out   <= 1'b1;
         bus.frame_start <= (r_rd_cnt == '0);
         bus.frame_last  <= (r_rd_cnt == c_LAST_BATCH);
      end else begin
         for (int l = 0; l < BATCH_SIZE; l++) begin
            bus.real_out[l]  <= {BW_DATA{1'b0}};
            bus.imag_out[l]  <= {BW_DATA{1'b0}};
            bus.index_out[l] <= {BW_IDX{1'b0}};
         end
         bus.valid_out   <= 1'b0;
         bus.frame_start <= 1'b0;
         bus.frame_last  <= 1'b0;
      end
   end

endmodule
`default_nettype wire
